// File: rtl/o_serdes_pkg.sv
// o_serdes_pkg
//   Shared types and constants for the output serializer.
//   - state_t   : serializer FSM states (IDLE, SHIFT)
//   - WIDTH_MIN : smallest supported word width
//   - WIDTH_MAX : largest supported word width
//   - cnt_width : width of the bit counter for a given word width
package o_serdes_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int WIDTH_MIN = 3;
  localparam int WIDTH_MAX = 10;

  // The counter only ever holds WIDTH-1 down to 0, so clog2(WIDTH) bits suffice.
  function automatic int cnt_width(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/o_serdes_hold.sv
// o_serdes_hold
//   One-word holding register between the fabric handshake and the shifter.
//   Ports:
//     clk       : clock, rising edge
//     rst       : synchronous reset, active-high; empties the register
//     en        : clock enable; register frozen when low
//     load      : capture word and mark the register full
//     consume   : shifter has taken the word; mark the register empty
//     word      : incoming parallel word
//     hold_v    : register holds a word
//     hold_data : held word
//   load and consume are never asserted together: load requires an empty
//   register, consume requires a full one.
module o_serdes_hold
  import o_serdes_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             consume,
  input  logic [WIDTH-1:0] word,
  output logic             hold_v,
  output logic [WIDTH-1:0] hold_data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v    <= 1'b0;
      hold_data <= '0;
    end else if (en) begin
      if (load) begin
        hold_v    <= 1'b1;
        hold_data <= word;
      end else if (consume) begin
        hold_v    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/o_serdes_tx.sv
// o_serdes_tx
//   Output serializer: accepts parallel words over a valid/ready handshake and
//   shifts them out one bit per enabled clock on Q. A one-word hold register
//   lets consecutive words stream without an idle bit between them.
//   Ports:
//     CLK       : clock, rising edge
//     RST       : synchronous reset, active-high
//     EN        : clock enable; all state frozen when low
//     D         : parallel word
//     D_VALID   : D valid this cycle
//     D_READY   : hold register can accept a word
//     Q         : registered serial data
//     OE        : registered output enable
//     BUSY      : shifting or hold register full
//     FIRST_BIT : Q carries the first transmitted bit of a word
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | nothing on Q; Q=IDLE_LEVEL, OE=!TRISTATE_IDLE
//   SHIFT | Q carries a data bit; bitcnt = bits left after it
module o_serdes_tx
  import o_serdes_pkg::*;
#(
  parameter int   WIDTH         = 8,
  parameter bit   MSB_FIRST     = 1'b0,
  parameter logic IDLE_LEVEL    = 1'b1,
  parameter bit   TRISTATE_IDLE = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] D,
  input  logic             D_VALID,
  output logic             D_READY,
  output logic             Q,
  output logic             OE,
  output logic             BUSY,
  output logic             FIRST_BIT
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("o_serdes_tx: WIDTH must lie within 3..10");
  end

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic          OE_IDLE  = ~TRISTATE_IDLE;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sr, sr_nx;
  logic [CW-1:0]    bitcnt, bitcnt_nx;
  logic             q_nx, oe_nx, first_nx;
  logic             hold_v, load, consume, reload;
  logic [WIDTH-1:0] hold_data;

  // Bit that sits at the output end of a word in transmit order.
  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Move the next bit to the output end.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // Ready depends on the registered hold flag only, so accepting a word and
  // consuming the held one can never coincide.
  assign D_READY = !hold_v && EN && !RST;
  assign load    = D_VALID && D_READY;
  assign BUSY    = (state == SHIFT) || hold_v;

  o_serdes_hold #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk       (CLK),
    .rst       (RST),
    .en        (EN),
    .load      (load),
    .consume   (consume),
    .word      (D),
    .hold_v    (hold_v),
    .hold_data (hold_data)
  );

  // A held word is taken whenever the shifter is empty or on its last bit,
  // which is what makes back-to-back words seamless.
  assign reload = hold_v && ((state == IDLE) || (bitcnt == '0));

  always_comb begin
    state_nx  = state;
    sr_nx     = sr;
    bitcnt_nx = bitcnt;
    q_nx      = Q;
    oe_nx     = OE;
    first_nx  = FIRST_BIT;
    consume   = 1'b0;
    if (reload) begin
      state_nx  = SHIFT;
      sr_nx     = hold_data;
      bitcnt_nx = LAST_IDX;
      q_nx      = head(hold_data);
      oe_nx     = 1'b1;
      first_nx  = 1'b1;
      consume   = 1'b1;
    end else if ((state == SHIFT) && (bitcnt != '0)) begin
      sr_nx     = advance(sr);
      bitcnt_nx = bitcnt - 1'b1;
      q_nx      = head(sr_nx);
      oe_nx     = 1'b1;
      first_nx  = 1'b0;
    end else begin
      state_nx  = IDLE;
      bitcnt_nx = '0;
      q_nx      = IDLE_LEVEL;
      oe_nx     = OE_IDLE;
      first_nx  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      sr        <= '0;
      bitcnt    <= '0;
      Q         <= IDLE_LEVEL;
      OE        <= OE_IDLE;
      FIRST_BIT <= 1'b0;
    end else if (EN) begin
      state     <= state_nx;
      sr        <= sr_nx;
      bitcnt    <= bitcnt_nx;
      Q         <= q_nx;
      OE        <= oe_nx;
      FIRST_BIT <= first_nx;
    end
  end

endmodule

// File: tb/tb_o_serdes_tx.sv
module tb_o_serdes_tx;

  logic       clk = 1'b0;
  logic       rst, en, d_valid;
  logic [7:0] d;
  logic       rdy0, rdy1, rdy2;
  logic       q0, q1, q2;
  logic       oe0, oe1, oe2;
  logic       busy0, busy1, busy2;
  logic       fb0, fb1, fb2;

  always #5 clk = ~clk;

  // Three configurations share the same stimulus.
  o_serdes_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1), .TRISTATE_IDLE(1'b0)) u0 (
    .CLK(clk), .RST(rst), .EN(en), .D(d), .D_VALID(d_valid), .D_READY(rdy0),
    .Q(q0), .OE(oe0), .BUSY(busy0), .FIRST_BIT(fb0));
  o_serdes_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0), .TRISTATE_IDLE(1'b1)) u1 (
    .CLK(clk), .RST(rst), .EN(en), .D(d), .D_VALID(d_valid), .D_READY(rdy1),
    .Q(q1), .OE(oe1), .BUSY(busy1), .FIRST_BIT(fb1));
  o_serdes_tx #(.WIDTH(3), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1), .TRISTATE_IDLE(1'b0)) u2 (
    .CLK(clk), .RST(rst), .EN(en), .D(d[2:0]), .D_VALID(d_valid), .D_READY(rdy2),
    .Q(q2), .OE(oe2), .BUSY(busy2), .FIRST_BIT(fb2));

  // Reference model: per instance, a held word and the word currently on the
  // line with the transmit-order index of the bit being shown.
  int mw[3]   = '{8, 8, 3};
  bit mmsb[3] = '{1'b0, 1'b1, 1'b0};
  bit mil[3]  = '{1'b1, 1'b0, 1'b1};
  bit mtri[3] = '{1'b0, 1'b1, 1'b0};
  bit hfull[3];
  int hword[3];
  bit act[3];
  int cword[3];
  int cidx[3];
  bit acc_last[3];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  function automatic logic tx_bit(input int k, input int w, input int i);
    int pos;
    pos = mmsb[k] ? (mw[k] - 1 - i) : i;
    return ((w >> pos) & 1) != 0;
  endfunction

  task automatic chk(input string tag, input int k, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s inst=%0d cyc=%0d observed=%b expected=%b", tag, k, cyc, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit e, input bit v, input logic [7:0] dv);
    logic [2:0] rv, qv, oev, bv, fv;
    @(negedge clk);
    rst = r; en = e; d_valid = v; d = dv;
    #1;
    rv = {rdy2, rdy1, rdy0};
    for (int k = 0; k < 3; k++)
      chk("d_ready", k, rv[k], !hfull[k] && e && !r);
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      acc_last[k] = 1'b0;
      if (r) begin
        hfull[k] = 1'b0;
        act[k]   = 1'b0;
      end else if (e) begin
        acc_last[k] = v && !hfull[k];
        if (act[k] && cidx[k] < mw[k] - 1) begin
          cidx[k]++;
        end else if (hfull[k]) begin
          cword[k] = hword[k];
          cidx[k]  = 0;
          act[k]   = 1'b1;
          hfull[k] = 1'b0;
        end else begin
          act[k] = 1'b0;
        end
        if (acc_last[k]) begin
          hfull[k] = 1'b1;
          hword[k] = int'(dv) & ((1 << mw[k]) - 1);
        end
      end
    end
    #1;
    cyc++;
    qv  = {q2, q1, q0};
    oev = {oe2, oe1, oe0};
    bv  = {busy2, busy1, busy0};
    fv  = {fb2, fb1, fb0};
    for (int k = 0; k < 3; k++) begin
      chk("q",         k, qv[k],  act[k] ? tx_bit(k, cword[k], cidx[k]) : mil[k]);
      chk("oe",        k, oev[k], act[k] ? 1'b1 : !mtri[k]);
      chk("first_bit", k, fv[k],  act[k] && cidx[k] == 0);
      chk("busy",      k, bv[k],  act[k] || hfull[k]);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  // Offer a word until the 8-bit LSB-first instance takes it.
  task automatic send(input logic [7:0] dv);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      step(1'b0, 1'b1, 1'b1, dv);
      got = acc_last[0];
    end
    checks++;
    assert (got === 1'b1) else begin
      errors++;
      $error("FAIL send_timeout word=%h observed=%b expected=1", dv, got);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; d_valid = 1'b0; d = 8'h00;
    step(1'b1, 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b0, 8'h00);

    // Single word
    send(8'hA5);
    idle(10);

    // Back-to-back words
    send(8'h0F);
    send(8'hF0);
    idle(20);

    // MSB-first / tristate-idle pattern (instance 1)
    send(8'h80);
    idle(10);

    // Enable stall mid-word
    send(8'hC3);
    idle(3);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'h55);
    idle(12);

    // Reset mid-word with a second word held
    send(8'h5A);
    send(8'h3C);
    idle(2);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    idle(12);

    // Three-bit stream
    send(8'h05);
    send(8'h02);
    send(8'h07);
    idle(24);

    // Randomized traffic
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 85,
           $urandom_range(0, 99) < 70, 8'($urandom));
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
